bcd_serial_add_ctrl: RTL and testbench
======================================

Name: bcd_serial_add_ctrl

Overview:
- Sequencing controller for the team's single-digit BCD adder slice (two 4-bit BCD digits plus carry-in, giving a digit sum plus carry-out).
- Performs a DIGITS-wide BCD addition by time-sharing one external digit slice, least-significant digit first, one digit per clock.
- Uses a start/busy/done handshake and flags invalid (>9) input digits.
- Sits between switch/register inputs and the 7-segment display decode.

Parameters:
DIGITS, 4, number of BCD digits per operand (min 1)
IDXW, 2, width of digit_idx; must satisfy 2^IDXW >= DIGITS

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  synchronous active-low reset
start  in  1  request; sampled only in IDLE
A  in  4*DIGITS  operand A, digit i at bits [4i+3:4i]
B  in  4*DIGITS  operand B, same packing
cin  in  1  carry into digit 0
busy  out  1  high from accept until DONE exits
done  out  1  one-cycle completion pulse
sum  out  4*DIGITS  BCD result, same packing
cout  out  1  carry out of the top digit
err  out  1  an operand digit was >9
digit_idx  out  IDXW  digit currently on the slice
dig_a  out  4  slice operand a
dig_b  out  4  slice operand b
dig_ci  out  1  slice carry-in
dig_s  in  4  slice digit sum, combinational from dig_a/dig_b/dig_ci
dig_co  in  1  slice carry-out, combinational

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Resetn is synchronous and active-low; it is sampled on the Clock rising edge.
  - When Resetn is low at an edge: state goes to IDLE; busy, done, sum, cout, err, digit_idx, dig_a, dig_b and dig_ci all go to 0; internal operand and carry registers are cleared.
  - Reset overrides any in-flight operation. No partial result survives it.
- States: IDLE, CHECK, ADD, DONE.
- IDLE:
  - busy = 0.
  - If start = 1 at an edge:
    - latch A, B and cin into internal registers;
    - clear err;
    - set busy = 1;
    - go to CHECK.
  - sum, cout and err hold their last result until that accept.
- CHECK (one cycle):
  - If any latched digit of A or B exceeds 9: err <= 1, sum <= 0, cout <= 0, go to DONE.
  - Otherwise: digit_idx <= 0, carry register <= latched cin, go to ADD.
- ADD:
  - dig_a and dig_b carry the latched digits at digit_idx; dig_ci carries the carry register.
  - At each edge: sum digit[digit_idx] <= dig_s, and carry register <= dig_co.
  - If digit_idx == DIGITS-1: cout <= dig_co and go to DONE. Otherwise digit_idx increments.
- DONE (one cycle):
  - done = 1 and busy = 1.
  - Next state is IDLE. In IDLE, busy = 0 and done = 0.
- dig_a, dig_b and dig_ci are 0 outside ADD. digit_idx is 0 outside ADD.
- Latency:
  - The edge that accepts start is edge 0.
  - done is high during the cycle following edge DIGITS+1, so it rises DIGITS+2 cycles after acceptance.
  - On the error path, done is high after edge 1.
- Handshake:
  - start is ignored while busy = 1, including during DONE.
  - A start held high continuously re-triggers on the first IDLE cycle after DONE.
  - Operands may change after acceptance without affecting the result.
- dig_s returned from the slice is trusted and is not range-checked.
- Widths:
  - The carry is 1 bit.
  - The maximum result is all-9s with cout = 1, e.g. 9999 + 9999 + 1 = 1 9999.

Optional Feature:
- Macro BCD_INPUT_CHECK_EN.
- Defined:
  - The CHECK state and err behave as above.
- Undefined:
  - There is no CHECK state; IDLE on accept goes directly to ADD with digit_idx = 0 and carry register = cin.
  - err is tied to 0.
  - Invalid digits are passed to the slice unmodified.
  - Latency shrinks by one: done rises DIGITS+1 cycles after acceptance.

Test Plan:
All scenarios use DIGITS = 4, with the bench modelling the slice behaviourally.
1. A=1234, B=5678, cin=0, start pulsed -> after DIGITS+2 cycles: done pulses for 1 cycle, sum=6912, cout=0, err=0; dig_a sequence 4,3,2,1 on digit_idx 0..3.
2. A=9999, B=0001, cin=0 -> sum=0000, cout=1; A=9999, B=9999, cin=1 -> sum=9999, cout=1.
3. A=12A4 (digit 1 = 0xA), B=0000 -> with BCD_INPUT_CHECK_EN: done 2 cycles after accept, err=1, sum=0000, cout=0, dig_a stays 0. Without the macro: err=0, done after 5 cycles.
4. Accept 1111+2222, then pulse start with A=5555 during ADD and during DONE -> both ignored; result 3333; only one done pulse.
5. Resetn low for one edge while digit_idx=2 -> next cycle state IDLE, busy=0, sum=0, cout=0, done never pulses. A new start of 0005+0005 then gives sum=0010, cout=0.
6. start held high continuously with A=0001, B=0001 -> back-to-back operations; each done pulse followed by exactly one IDLE cycle with busy=0; sum=0002 each time.

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// Sequencer that time-shares one external BCD digit slice, LSD first, one digit per clock.
// Define BCD_INPUT_CHECK_EN to add the CHECK state that flags operand digits above 9 on err.
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned IDXW   = 2
) (
    input  logic                  clock_i,
    input  logic                  resetn_i,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   a_i,
    input  logic [4*DIGITS-1:0]   b_i,
    input  logic                  cin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   sum_o,
    output logic                  cout_o,
    output logic                  err_o,
    output logic [IDXW-1:0]       digit_idx_o,
    output logic [3:0]            dig_a_o,
    output logic [3:0]            dig_b_o,
    output logic                  dig_ci_o,
    input  logic [3:0]            dig_s_i,
    input  logic                  dig_co_i
);

    typedef enum logic [1:0] {StIdle, StCheck, StAdd, StDone} state_e;

    localparam logic [IDXW-1:0] LastIdx = IDXW'(DIGITS - 1);

    state_e                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic [4*DIGITS-1:0]   sum_q;
    logic                  cout_q;
    logic [IDXW-1:0]       digit_idx_q;
    logic [IDXW-1:0]       digit_idx_d;
    logic [3:0]            dig_a_q;
    logic [3:0]            dig_b_q;
    // dig_ci_q doubles as the running carry register while in ADD.
    logic                  dig_ci_q;
    logic [4*DIGITS-1:0]   a_q;
    logic [4*DIGITS-1:0]   b_q;
`ifdef BCD_INPUT_CHECK_EN
    logic                  cin_q;
    logic                  err_q;
`endif

    function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] v,
                                            input logic [IDXW-1:0] i);
        logic [3:0] r;
        r = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (IDXW'(k) == i) r = v[4*k +: 4];
        end
        return r;
    endfunction

`ifdef BCD_INPUT_CHECK_EN
    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction
`endif

    assign digit_idx_d = digit_idx_q + IDXW'(1);

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            digit_idx_q <= '0;
            dig_a_q     <= '0;
            dig_b_q     <= '0;
            dig_ci_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
`ifdef BCD_INPUT_CHECK_EN
            cin_q       <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q    <= a_i;
                        b_q    <= b_i;
                        busy_q <= 1'b1;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
                        cin_q   <= cin_i;
                        err_q   <= 1'b0;
                        state_q <= StCheck;
`else
                        digit_idx_q <= '0;
                        dig_a_q     <= a_i[3:0];
                        dig_b_q     <= b_i[3:0];
                        dig_ci_q    <= cin_i;
                        state_q     <= StAdd;
`endif
                    end
                end
`ifdef BCD_INPUT_CHECK_EN
                StCheck: begin
                    if (has_bad_digit(a_q) || has_bad_digit(b_q)) begin
                        err_q   <= 1'b1;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        digit_idx_q <= '0;
                        dig_a_q     <= a_q[3:0];
                        dig_b_q     <= b_q[3:0];
                        dig_ci_q    <= cin_q;
                        state_q     <= StAdd;
                    end
                end
`endif
                StAdd: begin
                    for (int unsigned k = 0; k < DIGITS; k++) begin
                        if (digit_idx_q == IDXW'(k)) sum_q[4*k +: 4] <= dig_s_i;
                    end
                    if (digit_idx_q == LastIdx) begin
                        cout_q      <= dig_co_i;
                        digit_idx_q <= '0;
                        dig_a_q     <= '0;
                        dig_b_q     <= '0;
                        dig_ci_q    <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        digit_idx_q <= digit_idx_d;
                        dig_a_q     <= digit_at(a_q, digit_idx_d);
                        dig_b_q     <= digit_at(b_q, digit_idx_d);
                        dig_ci_q    <= dig_co_i;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign digit_idx_o = digit_idx_q;
    assign dig_a_o     = dig_a_q;
    assign dig_b_o     = dig_b_q;
    assign dig_ci_o    = dig_ci_q;
`ifdef BCD_INPUT_CHECK_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl with a behavioural BCD digit slice.
module tb_bcd_serial_add_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned IDXW   = 2;
`ifdef BCD_INPUT_CHECK_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif
    localparam int LAT = DIGITS + OFF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, err, dig_ci, dig_co;
    logic [15:0] sum;
    logic [1:0]  digit_idx;
    logic [3:0]  dig_a, dig_b, dig_s;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        e;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS), .IDXW(IDXW)) dut (
        .clock_i     (clk),
        .resetn_i    (resetn),
        .start_i     (start),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .busy_o      (busy),
        .done_o      (done),
        .sum_o       (sum),
        .cout_o      (cout),
        .err_o       (err),
        .digit_idx_o (digit_idx),
        .dig_a_o     (dig_a),
        .dig_b_o     (dig_b),
        .dig_ci_o    (dig_ci),
        .dig_s_i     (dig_s),
        .dig_co_i    (dig_co)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural digit slice: binary add, then +6 correction above 9.
    always_comb begin
        logic [4:0] t;
        dig_co = 1'b0;
        t = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, dig_ci};
        if (t > 5'd9) begin
            t = t + 5'd6;
            dig_co = 1'b1;
        end
        dig_s = t[3:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] nib(input logic [15:0] v, input int k);
        logic [15:0] t;
        t = v >> (4 * k);
        return t[3:0];
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_sum", 32'(sum), 32'(e.s));
                chk("sb_cout", 32'(cout), 32'(e.c));
                chk("sb_err", 32'(err), 32'(e.e));
                chk("sb_latency_cycle", 32'(cyc), 32'(e.due));
                chk("sb_busy_in_done", 32'(busy), 32'd1);
            end
        end
    end

    task automatic wait_idle(input string nm);
        int bud = 0;
        while (busy && bud < 40) begin
            @(negedge clk);
            bud++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_idle_timeout: got busy=1, required busy=0", nm);
        end
    endtask

    task automatic wait_done(input string nm);
        int bud = 0;
        while (!done && bud < 40) begin
            @(negedge clk);
            bud++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_done_timeout: got done=0, required done=1", nm);
            sb.delete();
        end
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic [15:0] es, input logic ec, input logic ee, input int lat);
        exp_t e;
        a = av;
        b = bv;
        cin = ci;
        start = 1'b1;
        e.s = es;
        e.c = ec;
        e.e = ee;
        e.due = cyc + 1 + lat;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                          input logic [15:0] es, input logic ec, input logic ee,
                          input bit errpath, input bit trace, input string nm);
        int lat;
        lat = errpath ? 1 : LAT;
        wait_idle(nm);
        issue(av, bv, ci, es, ec, ee, lat);
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        if (trace) begin
            for (int n = 0; n < lat; n++) begin
                logic [3:0] ea, eb;
                logic [1:0] ei;
                int k;
                k = n - OFF;
                ea = '0;
                eb = '0;
                ei = '0;
                if (!errpath && k >= 0) begin
                    ea = nib(av, k);
                    eb = nib(bv, k);
                    ei = k[1:0];
                end
                chk({nm, "_dig_a"}, 32'(dig_a), 32'(ea));
                chk({nm, "_dig_b"}, 32'(dig_b), 32'(eb));
                chk({nm, "_digit_idx"}, 32'(digit_idx), 32'(ei));
                @(negedge clk);
            end
        end
        wait_done(nm);
        @(negedge clk);
        chk({nm, "_busy_after"}, 32'(busy), 32'd0);
        chk({nm, "_done_after"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bud;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_idx", 32'(digit_idx), 32'd0);
        chk("rst_dig_a", 32'(dig_a), 32'd0);
        chk("rst_dig_b", 32'(dig_b), 32'd0);
        chk("rst_dig_ci", 32'(dig_ci), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Basic adds and boundaries
        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 1'b1, "t1");
        run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, "t2a");
        run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b1, "t2b");
        run_op(16'h4567, 16'h5433, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, "t2c");
        run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, "t2d");

        // Invalid digit
`ifdef BCD_INPUT_CHECK_EN
        run_op(16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, "t3");
        chk("t3_err_hold", 32'(err), 32'd1);
`else
        run_op(16'h12A4, 16'h0000, 1'b0, 16'h1304, 1'b0, 1'b0, 1'b0, 1'b1, "t3");
`endif
        run_op(16'h0008, 16'h0007, 1'b0, 16'h0015, 1'b0, 1'b0, 1'b0, 1'b0, "t3b");

        // start ignored during ADD and DONE
        wait_idle("t4");
        issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, LAT);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        a = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4");
        start = 1'b1;
        a = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        chk("t4_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t4_ignored", 32'(busy), 32'd0);
        repeat (8) @(negedge clk);
        chk("t4_hold_sum", 32'(sum), 32'h3333);

        // Reset mid-operation
        wait_idle("t5");
        a = 16'h4321;
        b = 16'h1111;
        cin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bud = 0;
        while (digit_idx !== 2'd2 && bud < 10) begin
            @(negedge clk);
            bud++;
        end
        chk("t5_reach_idx2", 32'(digit_idx), 32'd2);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_sum", 32'(sum), 32'd0);
        chk("t5_cout", 32'(cout), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_idx", 32'(digit_idx), 32'd0);
        chk("t5_dig_a", 32'(dig_a), 32'd0);
        repeat (10) @(negedge clk);
        run_op(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, "t5b");

        // start held high: back-to-back operations
        wait_idle("t6");
        a = 16'h0001;
        b = 16'h0001;
        cin = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.s = 16'h0002;
            e.c = 1'b0;
            e.e = 1'b0;
            e.due = cyc + 1 + k * (LAT + 2) + LAT;
            sb.push_back(e);
        end
        for (int k = 0; k < 3; k++) begin
            wait_done("t6");
            @(negedge clk);
            chk("t6_idle_gap", 32'(busy), 32'd0);
            if (k < 2) begin
                @(negedge clk);
                chk("t6_reaccept", 32'(busy), 32'd1);
            end else begin
                start = 1'b0;
            end
        end

        repeat (10) @(negedge clk);
        chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
